// File: rtl/score_keeper.sv
// Score registers for two players: converts level hits into single increments,
// enforces a post-hit cooldown, detects the win and holds the result until cleared.
module score_keeper #(
  parameter int SCORE_W         = 5,
  parameter int WIN_SCORE       = 10,
  parameter int COOLDOWN_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               clear,
  input  logic               hit_p1,
  input  logic               hit_p2,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               score_changed,
  output logic               game_over,
  output logic [1:0]         winner
);

  // state     | meaning
  // IDLE      | no match running, scores hold
  // PLAYING   | hit edges are counted
  // COOLDOWN  | all hits ignored for COOLDOWN_CYCLES cycles after a counted hit
  // GAME_OVER | a player reached WIN_SCORE; scores and winner hold until clear
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAYING   = 2'd1,
    COOLDOWN  = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam int CNT_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [SCORE_W-1:0] p1_nxt, p2_nxt;
  logic [SCORE_W-1:0] p1_inc, p2_inc;
  logic [1:0]         winner_nxt;
  logic               hit1_q, hit2_q;
  logic               edge1, edge2;
  logic               win1, win2;

  assign edge1  = hit_p1 & ~hit1_q;
  assign edge2  = hit_p2 & ~hit2_q;
  assign p1_inc = score_p1 + SCORE_W'(edge1);
  assign p2_inc = score_p2 + SCORE_W'(edge2);
  assign win1   = edge1 && (p1_inc == WIN_VAL);
  assign win2   = edge2 && (p2_inc == WIN_VAL);

  // Hit history samples in every state so an edge outside PLAYING is consumed, not queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit1_q <= 1'b0;
      hit2_q <= 1'b0;
    end else begin
      hit1_q <= hit_p1;
      hit2_q <= hit_p2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      score_p1      <= '0;
      score_p2      <= '0;
      winner        <= 2'b00;
      score_changed <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      score_p1      <= p1_nxt;
      score_p2      <= p2_nxt;
      winner        <= winner_nxt;
      score_changed <= (p1_nxt != score_p1) || (p2_nxt != score_p2);
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    p1_nxt     = score_p1;
    p2_nxt     = score_p2;
    winner_nxt = winner;
    if (clear) begin
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      p1_nxt     = '0;
      p2_nxt     = '0;
      winner_nxt = 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (start) state_nxt = PLAYING;
        end
        PLAYING: begin
          if (edge1 || edge2) begin
            p1_nxt = p1_inc;
            p2_nxt = p2_inc;
            if (win1 || win2) begin
              state_nxt  = GAME_OVER;
              winner_nxt = {win2, win1};
            end else begin
              cnt_nxt   = CNT_LOAD;
              state_nxt = COOLDOWN;
            end
          end
        end
        COOLDOWN: begin
          if (cnt == '0) state_nxt = PLAYING;
          else           cnt_nxt   = cnt - CNT_W'(1);
        end
        GAME_OVER: begin
          state_nxt = GAME_OVER;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    game_over = (state == GAME_OVER);
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with a cycle-level reference model of the
// scoring rules, a per-cycle compare process and literal spot checks.
module tb_score_keeper;

  localparam int SCORE_W  = 5;
  localparam int WIN      = 3;
  localparam int COOL     = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               clear = 1'b0;
  logic               hit_p1 = 1'b0;
  logic               hit_p2 = 1'b0;
  logic [SCORE_W-1:0] score_p1;
  logic [SCORE_W-1:0] score_p2;
  logic               score_changed;
  logic               game_over;
  logic [1:0]         winner;

  int errors = 0;
  int checks = 0;
  bit run    = 1'b0;

  score_keeper #(
    .SCORE_W(SCORE_W),
    .WIN_SCORE(WIN),
    .COOLDOWN_CYCLES(COOL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .clear(clear),
    .hit_p1(hit_p1),
    .hit_p2(hit_p2),
    .score_p1(score_p1),
    .score_p2(score_p2),
    .score_changed(score_changed),
    .game_over(game_over),
    .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a match is "active" once started; after each counted hit
  // the next m_block clock edges ignore every hit.
  int m_p1 = 0, m_p2 = 0, m_win = 0, m_block = 0;
  bit m_active = 0, m_over = 0, m_chg = 0, m_ph1 = 0, m_ph2 = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p1 = 0; m_p2 = 0; m_win = 0; m_block = 0;
      m_active = 0; m_over = 0; m_chg = 0; m_ph1 = 0; m_ph2 = 0;
    end else begin
      int old1, old2;
      bit e1, e2;
      old1 = m_p1;
      old2 = m_p2;
      e1 = hit_p1 && !m_ph1;
      e2 = hit_p2 && !m_ph2;
      m_ph1 = hit_p1;
      m_ph2 = hit_p2;
      if (clear) begin
        m_active = 0; m_over = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_block = 0;
      end else if (!m_active) begin
        if (start) m_active = 1;
      end else if (m_over) begin
        // results frozen
      end else if (m_block > 0) begin
        m_block--;
      end else if (e1 || e2) begin
        m_p1 += int'(e1);
        m_p2 += int'(e2);
        if (m_p1 == WIN || m_p2 == WIN) begin
          m_over = 1;
          m_win  = (m_p2 == WIN ? 2 : 0) + (m_p1 == WIN ? 1 : 0);
        end else begin
          m_block = COOL;
        end
      end
      m_chg = (m_p1 != old1) || (m_p2 != old2);
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("model_score_p1", int'(score_p1), m_p1);
      chk("model_score_p2", int'(score_p2), m_p2);
      chk("model_changed", int'(score_changed), int'(m_chg));
      chk("model_game_over", int'(game_over), int'(m_over));
      chk("model_winner", int'(winner), m_win);
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse(input bit a, input bit b);
    hit_p1 = a;
    hit_p2 = b;
    step(1);
    hit_p1 = 1'b0;
    hit_p2 = 1'b0;
  endtask

  task automatic start_match();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    int pulses;
    step(2);
    chk("reset_p1", int'(score_p1), 0);
    chk("reset_p2", int'(score_p2), 0);
    chk("reset_game_over", int'(game_over), 0);
    chk("reset_winner", int'(winner), 0);
    rst_n = 1'b1;
    run   = 1'b1;

    // start together with clear stays in IDLE, so a hit is not counted
    start = 1'b1; clear = 1'b1;
    step(1);
    start = 1'b0; clear = 1'b0;
    pulse(1, 0);
    chk("start_clear_idle", int'(score_p1), 0);
    step(1);

    // 1: held hit counts once
    start_match();
    hit_p1 = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (i == 0) chk("t1_first_hit", int'(score_p1), 1);
      if (score_changed) pulses++;
    end
    hit_p1 = 1'b0;
    chk("t1_held_p1", int'(score_p1), 1);
    chk("t1_pulses", pulses, 1);
    step(6);

    // 2: second pulse lands in cooldown, third after it
    pulse(0, 1);
    chk("t2_first", int'(score_p2), 1);
    step(1);
    pulse(0, 1);
    chk("t2_ignored", int'(score_p2), 1);
    step(3);
    pulse(0, 1);
    chk("t2_third", int'(score_p2), 2);
    step(6);

    // 3: P1 wins
    pulse(1, 0);
    chk("t3_p1_two", int'(score_p1), 2);
    step(6);
    pulse(1, 0);
    chk("t3_p1_win", int'(score_p1), 3);
    chk("t3_game_over", int'(game_over), 1);
    chk("t3_winner", int'(winner), 1);
    step(1);
    start = 1'b1;
    pulse(1, 1);
    start = 1'b0;
    step(2);
    pulse(0, 1);
    chk("t3_hold_p1", int'(score_p1), 3);
    chk("t3_hold_p2", int'(score_p2), 2);
    chk("t3_still_over", int'(game_over), 1);

    // 5: clear out of GAME_OVER
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("t5_p1", int'(score_p1), 0);
    chk("t5_p2", int'(score_p2), 0);
    chk("t5_game_over", int'(game_over), 0);
    chk("t5_winner", int'(winner), 0);
    chk("t5_changed", int'(score_changed), 1);
    start_match();
    pulse(1, 0);
    chk("t5_replay", int'(score_p1), 1);

    // 4: double hit to a draw
    step(6);
    pulse(0, 1);
    step(6);
    pulse(0, 1);
    step(6);
    pulse(1, 0);
    chk("t4_pre_p1", int'(score_p1), 2);
    chk("t4_pre_p2", int'(score_p2), 2);
    step(6);
    pulse(1, 1);
    chk("t4_p1", int'(score_p1), 3);
    chk("t4_p2", int'(score_p2), 3);
    chk("t4_winner", int'(winner), 3);
    chk("t4_game_over", int'(game_over), 1);
    chk("t4_changed", int'(score_changed), 1);
    step(1);
    chk("t4_single_pulse", int'(score_changed), 0);
    clear = 1'b1;
    step(1);
    clear = 1'b0;

    // 6: async reset in cooldown
    start_match();
    pulse(1, 0);
    step(6);
    pulse(1, 0);
    step(6);
    pulse(0, 1);
    chk("t6_pre_p1", int'(score_p1), 2);
    chk("t6_pre_p2", int'(score_p2), 1);
    step(2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_p1", int'(score_p1), 0);
    chk("t6_async_p2", int'(score_p2), 0);
    chk("t6_async_over", int'(game_over), 0);
    chk("t6_async_winner", int'(winner), 0);
    chk("t6_async_changed", int'(score_changed), 0);
    step(1);
    rst_n = 1'b1;
    start_match();
    hit_p1 = 1'b1;
    step(10);
    hit_p1 = 1'b0;
    chk("t6_held_once", int'(score_p1), 1);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Owns the score registers for both players and drives the 5-bit score buses consumed by the scoreboard display path.
- Converts level "hit" indications from the collision logic into single score increments.
- Applies a post-hit cooldown, detects the win condition and holds results until cleared.
- Sits between game/collision logic (upstream) and the two scoreboard displays (downstream).

Parameters:
- SCORE_W, 5, width of each score bus; matches the display input width.
- WIN_SCORE, 10, score at which a player wins; legal range 1..2^SCORE_W-1.
- COOLDOWN_CYCLES, 16, cycles after a counted hit during which all new hits are ignored; must be ≥1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level; begins a match when in IDLE.
- clear  input  1  synchronous abort; returns to IDLE and zeroes scores from any state.
- hit_p1  input  1  level from collision logic; P1 landed a hit, may stay high for many cycles.
- hit_p2  input  1  level; P2 landed a hit.
- score_p1  output  SCORE_W  P1 score, registered.
- score_p2  output  SCORE_W  P2 score, registered.
- score_changed  output  1  one-cycle pulse on the edge either score register changes.
- game_over  output  1  high while in GAME_OVER.
- winner  output  2  00 none, 01 P1, 10 P2, 11 draw; valid while game_over is high.

Behaviour:
- Reset (rst_n low, async):
  - State = IDLE.
  - Scores = 0, score_changed = 0, game_over = 0, winner = 00.
  - Cooldown counter = 0; hit history registers = 0.
- Edge detection:
  - Registers hit1_q and hit2_q sample hit_p1 and hit_p2 every cycle in all states.
  - A rising edge is hit & ~hit_q. A held level never counts twice.
  - An edge falling in IDLE, COOLDOWN or GAME_OVER is discarded, not queued.
- States:
  - IDLE: scores hold. If start=1 and clear=0, go to PLAYING.
  - PLAYING: on any rising edge, add 1 to each player with an edge on that same clk edge. Both edges together is a double hit: both scores increment. Then:
    - If any new score equals WIN_SCORE, go to GAME_OVER.
    - Otherwise load the counter with COOLDOWN_CYCLES-1 and go to COOLDOWN.
  - COOLDOWN: decrement each cycle. When the counter reads 0, go to PLAYING on the next edge. This gives exactly COOLDOWN_CYCLES cycles in COOLDOWN.
  - GAME_OVER: scores and winner hold. start is ignored; only clear or rst_n exit.
- clear:
  - Highest priority, from any state.
  - Next edge: state IDLE, scores 0, game_over 0, winner 00, counter 0.
  - score_changed pulses if either score was nonzero.
- Latency:
  - A hit input rising before edge k gives the updated score visible after edge k.
  - score_changed is high for the single cycle after edge k.
  - game_over and winner update on the same edge as the winning score.
- Winner encoding:
  - 01 if only P1 reaches WIN_SCORE; 10 if only P2.
  - 11 if both reach it on the same edge via a double hit.
- Arithmetic: scores are unsigned and never exceed WIN_SCORE, so no wrap is possible. The increment is guarded by the state check.
- start and clear together: clear wins; state stays IDLE.
- Asynchronous reset mid-match: all outputs return to reset values immediately, with no clock needed.

Test Plan:
Bench uses WIN_SCORE=3, COOLDOWN_CYCLES=4.
1. Reset then start pulse; hold hit_p1 high 20 cycles -> score_p1=1 one cycle after first high sample; stays 1; exactly one score_changed pulse.
2. In PLAYING, pulse hit_p2 1 cycle, pulse again 2 cycles later (inside cooldown), then again 6 cycles after the first -> score_p2 goes 0→1, ignores the 2nd pulse, goes to 2 on the 3rd.
3. Drive P1 to 2, then hit_p1 edge -> score_p1=3, game_over=1 and winner=01 on the same edge; later edges on either hit leave scores 3/x unchanged.
4. P1=2, P2=2, simultaneous hit_p1/hit_p2 edges -> both scores 3, winner=11, game_over=1, single score_changed pulse.
5. In GAME_OVER assert clear 1 cycle -> next cycle scores 0/0, game_over=0, winner=00, score_changed=1; start pulse returns to PLAYING.
6. Assert rst_n low asynchronously mid-COOLDOWN with scores 2/1 -> outputs zero before the next clk edge; held-high hit after release and start counts once.
